exam_operand_sequencer: RTL and testbench

- Controller for the 16-bit start/done compute unit on the DE2 board.
- Collects four operands (a, b, c, d) from the switches, one per press/release of the enter key.
- Holds the operands stable, then raises start and holds it until the unit returns done or a timeout expires.
- Registers the selected result (g or h) for display and exposes progress and status flags for the LEDs.

---
 rtl/exam_operand_sequencer.sv | 159 +++++++++++++++
 tb/tb_exam_operand_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exam_operand_sequencer.sv
// exam_operand_sequencer
// Operand loader and start/done handshake controller for a 16-bit compute unit.
// Four operands are captured from the switches, one per enter-key press and release.
// The controller then raises start and holds it until the unit reports done or a
// RUN-time budget expires. The selected result (g or h) is registered for display.
module exam_operand_sequencer #(
  parameter int              DATA_W  = 16,
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              enter_n,
  input  logic              sel,
  input  logic              done,
  input  logic [DATA_W-1:0] g_in,
  input  logic [DATA_W-1:0] h_in,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic              start,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        step,
  output logic [3:0]        captured,
  output logic              done_led,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    LOAD_PRESS = 3'd0,
    LOAD_REL   = 3'd1,
    RUN        = 3'd2,
    DONE       = 3'd3,
    ERR        = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_ONE;

  state_t            state_r;
  logic [1:0]        op_idx_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              en_meta_r;
  logic              en_sync_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] c_r;
  logic [DATA_W-1:0] d_r;
  logic [DATA_W-1:0] result_r;
  logic              start_r;
  logic [3:0]        step_r;
  logic [3:0]        captured_r;
  logic              done_led_r;
  logic              timeout_err_r;

  // Two-flop synchronizer for the asynchronous enter key; resets to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_meta_r <= 1'b1;
      en_sync_r <= 1'b1;
    end else begin
      en_meta_r <= enter_n;
      en_sync_r <= en_meta_r;
    end
  end

  // Sequencer FSM. It holds the operand, result, progress and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= LOAD_PRESS;
      op_idx_r      <= 2'd0;
      to_cnt_r      <= {TO_W{1'b0}};
      a_r           <= {DATA_W{1'b0}};
      b_r           <= {DATA_W{1'b0}};
      c_r           <= {DATA_W{1'b0}};
      d_r           <= {DATA_W{1'b0}};
      result_r      <= {DATA_W{1'b0}};
      start_r       <= 1'b0;
      step_r        <= 4'b0001;
      captured_r    <= 4'b0000;
      done_led_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD_PRESS: begin
          // Capture exactly once per press; the release wait below blocks repeats.
          if (!en_sync_r) begin
            case (op_idx_r)
              2'd0:    a_r <= sw_data;
              2'd1:    b_r <= sw_data;
              2'd2:    c_r <= sw_data;
              2'd3:    d_r <= sw_data;
              default: a_r <= a_r;
            endcase
            captured_r[op_idx_r] <= 1'b1;
            state_r              <= LOAD_REL;
          end
        end
        LOAD_REL: begin
          if (en_sync_r) begin
            if (op_idx_r == 2'd3) begin
              // The last operand is in; the operands freeze and start rises.
              state_r <= RUN;
              step_r  <= 4'b0000;
              start_r <= 1'b1;
            end else begin
              op_idx_r <= op_idx_r + 2'd1;
              step_r   <= {step_r[2:0], 1'b0};
              state_r  <= LOAD_PRESS;
            end
          end
        end
        RUN: begin
          result_r <= sel ? g_in : h_in;
          to_cnt_r <= to_cnt_r + TO_ONE;
          // done takes priority over a timeout that expires in the same cycle.
          if (done) begin
            state_r    <= DONE;
            done_led_r <= 1'b1;
          end else if (to_cnt_r == TO_LAST) begin
            state_r       <= ERR;
            start_r       <= 1'b0;
            timeout_err_r <= 1'b1;
          end
        end
        DONE: begin
          result_r   <= sel ? g_in : h_in;
          start_r    <= 1'b1;
          done_led_r <= 1'b1;
        end
        ERR: begin
          start_r       <= 1'b0;
          timeout_err_r <= 1'b1;
        end
        default: begin
          // Illegal encodings fall into the safe terminal error state.
          state_r       <= ERR;
          start_r       <= 1'b0;
          step_r        <= 4'b0000;
          timeout_err_r <= 1'b1;
        end
      endcase
    end
  end

  assign a           = a_r;
  assign b           = b_r;
  assign c           = c_r;
  assign d           = d_r;
  assign result      = result_r;
  assign start       = start_r;
  assign step        = step_r;
  assign captured    = captured_r;
  assign done_led    = done_led_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_exam_operand_sequencer.sv
// Directed self-checking bench for exam_operand_sequencer (TIMEOUT shortened to 100).
module tb_exam_operand_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] sw_data;
  logic        enter_n;
  logic        sel;
  logic        done;
  logic [15:0] g_in;
  logic [15:0] h_in;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [15:0] d;
  logic        start;
  logic [15:0] result;
  logic [3:0]  step;
  logic [3:0]  captured;
  logic        done_led;
  logic        timeout_err;

  int vec_cnt;
  int err_cnt;

  exam_operand_sequencer #(
    .DATA_W  (16),
    .TO_W    (24),
    .TIMEOUT (24'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_data     (sw_data),
    .enter_n     (enter_n),
    .sel         (sel),
    .done        (done),
    .g_in        (g_in),
    .h_in        (h_in),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .start       (start),
    .result      (result),
    .step        (step),
    .captured    (captured),
    .done_led    (done_led),
    .timeout_err (timeout_err)
  );

  // 10 ns clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_a"}, a, 32'h0);
    check_eq({tag, "_b"}, b, 32'h0);
    check_eq({tag, "_c"}, c, 32'h0);
    check_eq({tag, "_d"}, d, 32'h0);
    check_eq({tag, "_result"}, result, 32'h0);
    check_eq({tag, "_start"}, start, 32'h0);
    check_eq({tag, "_step"}, step, 32'h1);
    check_eq({tag, "_captured"}, captured, 32'h0);
    check_eq({tag, "_done_led"}, done_led, 32'h0);
    check_eq({tag, "_timeout_err"}, timeout_err, 32'h0);
  endtask

  task automatic apply_reset();
    enter_n = 1'b1;
    done    = 1'b0;
    sel     = 1'b0;
    g_in    = 16'h0000;
    h_in    = 16'h0000;
    sw_data = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] op_of(input int k);
    case (k)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Press and release for operand slot k. Entry starts from a negedge in LOAD_PRESS.
  // It returns at the negedge right after the edge that acts on the release.
  task automatic load_op(input int k, input logic [15:0] val);
    int cap_before;
    int cap_after;
    int step_after;
    cap_before = (1 << k) - 1;
    cap_after  = (1 << (k + 1)) - 1;
    step_after = (k < 3) ? (1 << (k + 1)) : 0;
    check_eq("step_before_press", step, 32'(1 << k));
    sw_data = val;
    enter_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("captured_before_3rd_edge", captured, 32'(cap_before));
    @(negedge clk);
    check_eq("captured_after_press", captured, 32'(cap_after));
    check_eq("operand_value", op_of(k), 32'(val));
    enter_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("step_before_release_seen", step, 32'(1 << k));
    @(negedge clk);
    check_eq("step_after_release", step, 32'(step_after));
    check_eq("start_after_release", start, (k == 3) ? 32'h1 : 32'h0);
  endtask

  task automatic load_all();
    load_op(0, 16'h0001);
    load_op(1, 16'h0022);
    load_op(2, 16'h0333);
    load_op(3, 16'h4444);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst     = 1'b0;
    enter_n = 1'b1;
    done    = 1'b0;
    sel     = 1'b0;
    g_in    = 16'h0000;
    h_in    = 16'h0000;
    sw_data = 16'h0000;

    apply_reset();
    check_reset_state("reset");

    // A held key captures once; later switch changes are ignored until release.
    sw_data = 16'h00AA;
    enter_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("hold_a_first", a, 32'h00AA);
    check_eq("hold_cap_first", captured, 32'h1);
    sw_data = 16'h00BB;
    repeat (997) @(negedge clk);
    check_eq("hold_a_after", a, 32'h00AA);
    check_eq("hold_b_untouched", b, 32'h0);
    check_eq("hold_cap_after", captured, 32'h1);
    check_eq("hold_step_after", step, 32'h1);
    enter_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("hold_step_release", step, 32'h2);
    check_eq("hold_a_release", a, 32'h00AA);

    // Capture b, then assert reset asynchronously while waiting for c.
    load_op(1, 16'h0BBB);
    #2 rst = 1'b0;
    #1 check_reset_state("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load_op(0, 16'h0055);
    check_eq("post_reset_b", b, 32'h0);

    // Full load, run, and done with g/h selection.
    apply_reset();
    load_all();
    check_eq("load_a", a, 32'h0001);
    check_eq("load_b", b, 32'h0022);
    check_eq("load_c", c, 32'h0333);
    check_eq("load_d", d, 32'h4444);
    check_eq("load_captured", captured, 32'hF);
    // Operands stay frozen in RUN even if the key is pressed again.
    sw_data = 16'hDEAD;
    enter_n = 1'b0;
    repeat (5) @(negedge clk);
    enter_n = 1'b1;
    repeat (44) @(negedge clk);
    check_eq("run_frozen_a", a, 32'h0001);
    check_eq("run_frozen_d", d, 32'h4444);
    check_eq("run_start", start, 32'h1);
    check_eq("run_done_led", done_led, 32'h0);
    g_in = 16'h1234;
    h_in = 16'h5678;
    sel  = 1'b1;
    done = 1'b1;
    @(negedge clk);
    check_eq("done_led", done_led, 32'h1);
    check_eq("done_start", start, 32'h1);
    check_eq("done_result_g", result, 32'h1234);
    check_eq("done_timeout_err", timeout_err, 32'h0);
    done = 1'b0;
    sel  = 1'b0;
    @(negedge clk);
    check_eq("done_result_h", result, 32'h5678);
    check_eq("done_led_sticky", done_led, 32'h1);
    check_eq("done_start_held", start, 32'h1);
    repeat (60) @(negedge clk);
    check_eq("done_no_timeout", timeout_err, 32'h0);

    // Timeout: RUN cycle 100 without done enters ERR.
    apply_reset();
    load_all();
    g_in = 16'hAAAA;
    sel  = 1'b1;
    repeat (99) @(negedge clk);
    check_eq("to_pre_start", start, 32'h1);
    check_eq("to_pre_err", timeout_err, 32'h0);
    check_eq("to_run_result", result, 32'hAAAA);
    @(negedge clk);
    check_eq("to_err", timeout_err, 32'h1);
    check_eq("to_start_low", start, 32'h0);
    g_in = 16'h5555;
    done = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("to_done_ignored", done_led, 32'h0);
    check_eq("to_err_sticky", timeout_err, 32'h1);
    check_eq("to_start_stays_low", start, 32'h0);
    check_eq("to_result_held", result, 32'hAAAA);
    done = 1'b0;

    // done in the same cycle as the last timeout count wins.
    apply_reset();
    load_all();
    repeat (99) @(negedge clk);
    check_eq("race_pre_err", timeout_err, 32'h0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_eq("race_done_led", done_led, 32'h1);
    check_eq("race_timeout_err", timeout_err, 32'h0);
    check_eq("race_start", start, 32'h1);
    repeat (5) @(negedge clk);
    check_eq("race_err_stays_low", timeout_err, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
